// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, sitting beside data memory on the core's data port.
// Optional TX-drained interrupt and CTRL.irq_en are built only when UART_TX_IRQ_EN is defined.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRW,
   input  logic [31:0] addr,
   input  logic [31:0] DataW,
   output logic [31:0] DataR,
   output logic        hit,
   output logic        tx,
   output logic        irq
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [15:0]      DIV_LOAD = 16'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t           state_r, state_next_s;
   logic [15:0]      baud_r, baud_next_s;
   logic [2:0]       bit_idx_r, bit_idx_next_s;
   logic [7:0]       shift_r, shift_next_s;
   logic             tx_r, tx_next_s;

   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             overflow_r;
   logic             enable_r;
   logic             irq_en_s;

   logic             hit_s, store_s, push_req_s, push_ok_s, pop_s;
   logic             status_wr_s, ctrl_wr_s;
   logic             empty_s, full_s, busy_s;
   logic [3:0]       offset_s;
   logic [31:0]      rdata_s;

   assign hit_s       = (addr[31:4] == BASE_ADDR[31:4]);
   assign offset_s    = addr[3:0];
   assign store_s     = MemRW & hit_s;
   assign push_req_s  = store_s & (offset_s == 4'h0);
   assign status_wr_s = store_s & (offset_s == 4'h4);
   assign ctrl_wr_s   = store_s & (offset_s == 4'h8);

   assign empty_s   = (count_r == {CNT_W{1'b0}});
   assign full_s    = (count_r == DEPTH_C);
   assign busy_s    = (state_r != S_IDLE);
   assign pop_s     = (state_r == S_IDLE) & enable_r & ~empty_s;
   // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle.
   assign push_ok_s = push_req_s & (~full_s | pop_s);

   // Register read mux; STATUS reflects pre-edge state.
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (hit_s) begin
         case (offset_s)
            4'h4:    rdata_s = {16'h0000, 8'(count_r), 4'h0, overflow_r, busy_s, empty_s, full_s};
            4'h8:    rdata_s = {30'h0000_0000, irq_en_s, enable_r};
            default: rdata_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   assign DataR = rdata_s;
   assign hit   = hit_s;
   assign tx    = tx_r;

   // Next-state, baud and line-level logic for the serialiser.
   always_comb begin
      state_next_s   = state_r;
      baud_next_s    = baud_r;
      bit_idx_next_s = bit_idx_r;
      shift_next_s   = shift_r;
      tx_next_s      = tx_r;
      case (state_r)
         S_IDLE: begin
            tx_next_s = 1'b1;
            if (pop_s) begin
               state_next_s   = S_START;
               baud_next_s    = DIV_LOAD;
               bit_idx_next_s = 3'd0;
               shift_next_s   = mem_r[rd_ptr_r];
               tx_next_s      = 1'b0;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_START: begin
            if (baud_r == 16'd0) begin
               state_next_s = S_DATA;
               baud_next_s  = DIV_LOAD;
               tx_next_s    = shift_r[0];
            end else begin
               baud_next_s = baud_r - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_r == 16'd0) begin
               baud_next_s = DIV_LOAD;
               if (bit_idx_r == 3'd7) begin
                  state_next_s = S_STOP;
                  tx_next_s    = 1'b1;
               end else begin
                  bit_idx_next_s = bit_idx_r + 3'd1;
                  shift_next_s   = {1'b0, shift_r[7:1]};
                  tx_next_s      = shift_r[1];
               end
            end else begin
               baud_next_s = baud_r - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_r == 16'd0) begin
               state_next_s = S_IDLE;
               tx_next_s    = 1'b1;
            end else begin
               baud_next_s = baud_r - 16'd1;
            end
         end
         default: begin
            state_next_s = S_IDLE;
            baud_next_s  = 16'd0;
            tx_next_s    = 1'b1;
         end
      endcase
   end

   // Serialiser state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         baud_r    <= 16'd0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
      end else begin
         state_r   <= state_next_s;
         baud_r    <= baud_next_s;
         bit_idx_r <= bit_idx_next_s;
         shift_r   <= shift_next_s;
         tx_r      <= tx_next_s;
      end
   end

   // FIFO storage; only entries already written are ever popped.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= DataW[7:0];
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         else           wr_ptr_r <= wr_ptr_r;
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         else       rd_ptr_r <= rd_ptr_r;
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow (a new drop beats a same-cycle clear) and enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
         enable_r   <= 1'b1;
      end else begin
         if (push_req_s && !push_ok_s)      overflow_r <= 1'b1;
         else if (status_wr_s && DataW[3]) overflow_r <= 1'b0;
         else                               overflow_r <= overflow_r;
         if (ctrl_wr_s) enable_r <= DataW[0];
         else           enable_r <= enable_r;
      end
   end

`ifdef UART_TX_IRQ_EN
   logic irq_en_r;
   logic irq_r;

   // Interrupt enable and level TX-drained interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_r <= 1'b0;
         irq_r    <= 1'b0;
      end else begin
         if (ctrl_wr_s) irq_en_r <= DataW[1];
         else           irq_en_r <= irq_en_r;
         irq_r <= irq_en_r & empty_s & ~busy_s;
      end
   end

   assign irq_en_s = irq_en_r;
   assign irq      = irq_r;
`else
   assign irq_en_s = 1'b0;
   assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLK_DIV=4; irq expectations follow UART_TX_IRQ_EN.
module tb_mmio_uart_tx;

   localparam int DIV = 4;

   logic        clk;
   logic        rst_n;
   logic        MemRW;
   logic [31:0] addr;
   logic [31:0] DataW;
   logic [31:0] DataR;
   logic        hit;
   logic        tx;
   logic        irq;

   int total;
   int bad;

   mmio_uart_tx #(
      .BASE_ADDR (32'h0000_1000),
      .CLK_DIV   (DIV),
      .FIFO_DEPTH(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .MemRW(MemRW),
      .addr (addr),
      .DataW(DataW),
      .DataR(DataR),
      .hit  (hit),
      .tx   (tx),
      .irq  (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      MemRW = 1'b0;
      addr  = 32'h0;
      DataW = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Store commits at the next rising edge; returns 1 time unit after it.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemRW = 1'b1;
      addr  = a;
      DataW = d;
      @(posedge clk);
      #1;
      MemRW = 1'b0;
      addr  = 32'h0;
      DataW = 32'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic h);
      MemRW = 1'b0;
      addr  = a;
      #1;
      v = DataR;
      h = hit;
   endtask

   // Checks one full frame cycle by cycle, then the single idle cycle after it.
   task automatic expect_frame(input logic [7:0] d);
      logic exp_bit;
      MemRW = 1'b0;
      addr  = 32'h0000_1004;
      for (int b = 0; b < 10; b++) begin
         if (b == 0)      exp_bit = 1'b0;
         else if (b == 9) exp_bit = 1'b1;
         else             exp_bit = d[b-1];
         for (int c = 0; c < DIV; c++) begin
            @(posedge clk);
            #1;
            chk("tx_bit", 32'(tx), 32'(exp_bit));
            chk("busy_frame", 32'(DataR[2]), 32'h1);
            chk("irq_frame", 32'(irq), 32'h0);
         end
      end
      @(posedge clk);
      #1;
      chk("tx_idle_gap", 32'(tx), 32'h1);
      chk("busy_idle_gap", 32'(DataR[2]), 32'h0);
      addr = 32'h0;
   endtask

   initial begin
      logic [31:0] v;
      logic        h;
      logic [31:0] irq_en_rb;
      logic [31:0] irq_exp;
      total = 0;
      bad   = 0;
      do_reset();

      // reset state
      chk("rst_tx", 32'(tx), 32'h1);
      chk("rst_irq", 32'(irq), 32'h0);
      rd(32'h0000_1004, v, h);
      chk("rst_status", v, 32'h0000_0002);
      rd(32'h0000_1008, v, h);
      chk("rst_ctrl", v, 32'h0000_0001);

      // address decode
      rd(32'h0000_1010, v, h);
      chk("hit_out", 32'(h), 32'h0);
      chk("data_out", v, 32'h0);
      rd(32'h0000_100C, v, h);
      chk("hit_0c", 32'(h), 32'h1);
      chk("data_0c", v, 32'h0);
      rd(32'h0000_1000, v, h);
      chk("data_txdata", v, 32'h0);

      // single frame 0x55
      store(32'h0000_1000, 32'h0000_0055);
      expect_frame(8'h55);
      rd(32'h0000_1004, v, h);
      chk("status_after_55", v, 32'h0000_0002);

      // overflow, W1C and drain of a full FIFO
      store(32'h0000_1008, 32'h0);
      for (int i = 0; i < 9; i++) store(32'h0000_1000, 32'h10 + 32'(i));
      rd(32'h0000_1004, v, h);
      chk("status_ovf", v, 32'h0000_0809);
      store(32'h0000_1004, 32'h0000_0008);
      rd(32'h0000_1004, v, h);
      chk("status_w1c", v, 32'h0000_0801);
      store(32'h0000_1008, 32'h0000_0001);
      for (int i = 0; i < 8; i++) expect_frame(8'h10 + 8'(i));
      rd(32'h0000_1004, v, h);
      chk("status_drained", v, 32'h0000_0002);

      // clearing enable mid-frame keeps the queue
      do_reset();
      store(32'h0000_1000, 32'h0000_003C);
      store(32'h0000_1000, 32'h0000_00C3);
      store(32'h0000_1000, 32'h0000_000F);
      repeat (8) @(posedge clk);
      #1;
      store(32'h0000_1008, 32'h0);
      v = 32'h4;
      for (int i = 0; i < 100 && v[2]; i++) begin
         @(posedge clk);
         #1;
         rd(32'h0000_1004, v, h);
      end
      chk("busy_fall", 32'(v[2]), 32'h0);
      chk("status_held", v, 32'h0000_0200);
      repeat (10) @(posedge clk);
      #1;
      chk("tx_held_idle", 32'(tx), 32'h1);
      rd(32'h0000_1004, v, h);
      chk("status_held_later", v, 32'h0000_0200);

      // async reset during DATA bit 3 of 0xA5
      do_reset();
      store(32'h0000_1000, 32'h0000_00A5);
      repeat (18) @(posedge clk);
      #1;
      chk("tx_bit3", 32'(tx), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("tx_async_rst", 32'(tx), 32'h1);
      rd(32'h0000_1004, v, h);
      chk("status_in_rst", v, 32'h0000_0002);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         chk("tx_after_rst", 32'(tx), 32'h1);
      end

      // interrupt behaviour
`ifdef UART_TX_IRQ_EN
      irq_en_rb = 32'h0000_0003;
      irq_exp   = 32'h1;
`else
      irq_en_rb = 32'h0000_0001;
      irq_exp   = 32'h0;
`endif
      store(32'h0000_1008, 32'h0000_0003);
      rd(32'h0000_1008, v, h);
      chk("ctrl_irq_en", v, irq_en_rb);
      @(posedge clk);
      #1;
      chk("irq_idle", 32'(irq), irq_exp);
      store(32'h0000_1000, 32'h0000_0081);
      expect_frame(8'h81);
      chk("irq_lag", 32'(irq), 32'h0);
      @(posedge clk);
      #1;
      chk("irq_rise", 32'(irq), irq_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
